// File: rtl/ncgb_mapper_sync.sv
// Clocked MBC5-style cartridge mapper: synchronised, glitch-filtered /WR commits and a lockable game select.
// Optional build macro NCGB_MBC1_COMPAT_EN switches the ROM bank decode to MBC1 semantics.
module ncgb_mapper_sync #(
    parameter int ROM_BANK_W = 9,
    parameter int RAM_BANK_W = 4,
    parameter int GAME_SEL_W = 2,
    parameter int WR_FILT    = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [3:0]            GB_A,
    input  logic [7:0]            GB_D,
    input  logic                  GB_WR,
    input  logic                  GB_RD,
    input  logic                  GB_CS,
    output logic [ROM_BANK_W-1:0] ROM_A,
    output logic [RAM_BANK_W-1:0] RAM_A,
    output logic                  ROM_CS,
    output logic                  RAM_CS,
    output logic                  DDIR
);

    // IDLE wait /WR low | LOW count filtered low samples | ARMED track bus until /WR high | COMMIT update registers
    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_ARMED, ST_COMMIT} state_t;

    localparam int CNT_W = (WR_FILT < 2) ? 1 : $clog2(WR_FILT + 1);
    localparam int RBX   = (ROM_BANK_W > 9) ? ROM_BANK_W : 9;
    localparam logic [ROM_BANK_W-1:0] ROM_KEEP = {ROM_BANK_W{1'b1}} >> GAME_SEL_W;
    localparam logic [RAM_BANK_W-1:0] RAM_KEEP = {RAM_BANK_W{1'b1}} >> GAME_SEL_W;

    logic                  wr_meta_q, wr_s_q;
    logic [3:0]            a_q, a_s_q, a_lat_q;
    logic [7:0]            d_q, d_s_q, d_lat_q;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic                  lat_en, commit;
    logic [ROM_BANK_W-1:0] rom_bank_q, rom_bank_d;
    logic [RAM_BANK_W-1:0] ram_bank_q, ram_bank_d;
    logic [GAME_SEL_W-1:0] game_sel_q, game_sel_d;
    logic                  ram_en_q, ram_en_d;
    logic                  menu_win_q, menu_win_d;
    logic                  game_lock_q, game_lock_d;
    logic [RBX-1:0]        rb_x;
    logic [ROM_BANK_W-1:0] rom_base;
    logic                  unused_cs;

    assign unused_cs = GB_CS;

    // Bus stage a_s/d_s lines up with wr_s so the latched pair matches the /WR sample.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_meta_q <= 1'b1;
            wr_s_q    <= 1'b1;
            a_q       <= '0;
            d_q       <= '0;
            a_s_q     <= '0;
            d_s_q     <= '0;
        end else begin
            wr_meta_q <= GB_WR;
            wr_s_q    <= wr_meta_q;
            a_q       <= GB_A;
            d_q       <= GB_D;
            a_s_q     <= a_q;
            d_s_q     <= d_q;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_en  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!wr_s_q) begin
                    lat_en  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = (WR_FILT <= 1) ? ST_ARMED : ST_LOW;
                end
            end
            ST_LOW: begin
                if (!wr_s_q) begin
                    lat_en = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == CNT_W'(WR_FILT)) state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!wr_s_q) lat_en = 1'b1;
                else         state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rb_x        = RBX'(rom_bank_q);
        ram_bank_d  = ram_bank_q;
        ram_en_d    = ram_en_q;
        menu_win_d  = menu_win_q;
        game_sel_d  = game_sel_q;
        game_lock_d = game_lock_q;
        if (commit) begin
            case (a_lat_q)
                4'h0, 4'h1: ram_en_d = (d_lat_q[3:0] == 4'hA);
`ifdef NCGB_MBC1_COMPAT_EN
                4'h2, 4'h3: rb_x[4:0] = (d_lat_q[4:0] == 5'd0) ? 5'd1 : d_lat_q[4:0];
`else
                4'h2: rb_x[7:0] = d_lat_q;
                4'h3: if (ROM_BANK_W > 8) rb_x[8] = d_lat_q[0];
`endif
                4'h4, 4'h5: begin
                    ram_bank_d = d_lat_q[RAM_BANK_W-1:0];
                    menu_win_d = d_lat_q[4] & ~game_lock_q;
`ifdef NCGB_MBC1_COMPAT_EN
                    rb_x[6:5]  = d_lat_q[1:0];
`endif
                end
                4'hA: if (menu_win_q && d_lat_q[0]) game_lock_d = 1'b1;
                4'hB: if (menu_win_q && !game_lock_q) game_sel_d = d_lat_q[GAME_SEL_W-1:0];
                default: ;
            endcase
        end
`ifdef NCGB_MBC1_COMPAT_EN
        rb_x[8:7] = 2'b00;
`endif
        rom_bank_d = rb_x[ROM_BANK_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_lat_q     <= '0;
            d_lat_q     <= '0;
            rom_bank_q  <= ROM_BANK_W'(1);
            ram_bank_q  <= '0;
            ram_en_q    <= 1'b0;
            menu_win_q  <= 1'b0;
            game_sel_q  <= '0;
            game_lock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (lat_en) begin
                a_lat_q <= a_s_q;
                d_lat_q <= d_s_q;
            end
            rom_bank_q  <= rom_bank_d;
            ram_bank_q  <= ram_bank_d;
            ram_en_q    <= ram_en_d;
            menu_win_q  <= menu_win_d;
            game_sel_q  <= game_sel_d;
            game_lock_q <= game_lock_d;
        end
    end

    // Access paths are purely combinational from the live address.
    assign ROM_CS   = GB_A[3];
    assign RAM_CS   = !((GB_A[3:1] == 3'b101) && ram_en_q && !menu_win_q);
    assign rom_base = (GB_A[3:2] == 2'b00) ? '0 : rom_bank_q;
    assign ROM_A    = game_lock_q
                    ? ((rom_base & ROM_KEEP) | (ROM_BANK_W'(game_sel_q) << (ROM_BANK_W - GAME_SEL_W)))
                    : rom_base;
    assign RAM_A    = game_lock_q
                    ? ((ram_bank_q & RAM_KEEP) | (RAM_BANK_W'(game_sel_q) << (RAM_BANK_W - GAME_SEL_W)))
                    : ram_bank_q;
    assign DDIR     = (!ROM_CS || !RAM_CS) && !GB_RD;

endmodule

// File: tb/tb_ncgb_mapper_sync.sv
// Bench for ncgb_mapper_sync: directed bring-up sequence plus randomized bus writes against a register-level model.
module tb_ncgb_mapper_sync;
    localparam int ROM_BANK_W = 9;
    localparam int RAM_BANK_W = 4;
    localparam int GAME_SEL_W = 2;
    localparam int WR_FILT    = 3;

    logic                  CLK = 1'b0;
    logic                  RST_N = 1'b0;
    logic [3:0]            GB_A = 4'h0;
    logic [7:0]            GB_D = 8'h00;
    logic                  GB_WR = 1'b1;
    logic                  GB_RD = 1'b1;
    logic                  GB_CS = 1'b1;
    logic [ROM_BANK_W-1:0] ROM_A;
    logic [RAM_BANK_W-1:0] RAM_A;
    logic                  ROM_CS, RAM_CS, DDIR;

    int n_vec = 0;
    int n_err = 0;
    int m_rom, m_ram, m_en, m_menu, m_sel, m_lock;

    ncgb_mapper_sync #(
        .ROM_BANK_W(ROM_BANK_W), .RAM_BANK_W(RAM_BANK_W),
        .GAME_SEL_W(GAME_SEL_W), .WR_FILT(WR_FILT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .GB_A(GB_A), .GB_D(GB_D), .GB_WR(GB_WR),
        .GB_RD(GB_RD), .GB_CS(GB_CS), .ROM_A(ROM_A), .RAM_A(RAM_A),
        .ROM_CS(ROM_CS), .RAM_CS(RAM_CS), .DDIR(DDIR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rom = 1; m_ram = 0; m_en = 0; m_menu = 0; m_sel = 0; m_lock = 0;
    endtask

    task automatic model_write(input int a, input int d);
        case (a)
            0, 1:  m_en = ((d % 16) == 10) ? 1 : 0;
            2:     m_rom = (m_rom / 256) * 256 + d;
            3:     m_rom = (m_rom % 256) + (d % 2) * 256;
            4, 5: begin
                m_ram  = d % 16;
                m_menu = m_lock ? 0 : (d / 16) % 2;
            end
            10:    if (m_menu && (d % 2) == 1) m_lock = 1;
            11:    if (m_menu && !m_lock) m_sel = d % 4;
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge CLK);
        GB_WR = 1'b1;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        @(negedge CLK);
    endtask

    task automatic bus_write(input int a, input int d, input int low_cyc);
        @(negedge CLK);
        GB_A  = 4'(a);
        GB_D  = 8'(d);
        GB_RD = 1'b1;
        GB_WR = 1'b0;
        repeat (low_cyc) @(negedge CLK);
        GB_WR = 1'b1;
        repeat (6) @(negedge CLK);
        if (low_cyc >= WR_FILT) model_write(a, d);
    endtask

    task automatic probe(input int a, input int rd);
        int e_rom_cs, e_ram_cs, e_rom_a, e_ram_a, e_ddir;
        GB_A  = 4'(a);
        GB_RD = rd[0];
        #1;
        e_rom_cs = (a >= 8) ? 1 : 0;
        e_ram_cs = ((a == 10 || a == 11) && m_en && !m_menu) ? 0 : 1;
        e_rom_a  = (a < 4) ? 0 : m_rom;
        e_ram_a  = m_ram;
        if (m_lock) begin
            e_rom_a = (e_rom_a % 128) + m_sel * 128;
            e_ram_a = (e_ram_a % 4) + m_sel * 4;
        end
        e_ddir = ((e_rom_cs == 0 || e_ram_cs == 0) && rd == 0) ? 1 : 0;
        chk("rom_cs", 32'(ROM_CS), 32'(e_rom_cs));
        chk("ram_cs", 32'(RAM_CS), 32'(e_ram_cs));
        chk("rom_a",  32'(ROM_A),  32'(e_rom_a));
        chk("ram_a",  32'(RAM_A),  32'(e_ram_a));
        chk("ddir",   32'(DDIR),   32'(e_ddir));
        GB_RD = 1'b1;
    endtask

    initial begin
        int a, d, low;
        model_reset();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        probe(4, 0);
        chk("rst_rom_a_4", 32'(ROM_A), 32'h001);
        chk("rst_rom_cs_4", 32'(ROM_CS), 32'h0);
        chk("rst_ram_cs_4", 32'(RAM_CS), 32'h1);
        probe(0, 1);
        chk("rst_rom_a_0", 32'(ROM_A), 32'h000);

        bus_write(2, 8'h5A, 6);
        probe(4, 0);
        chk("bank_5a", 32'(ROM_A), 32'h05A);
        bus_write(3, 8'h01, 6);
        probe(5, 0);
        chk("bank_15a", 32'(ROM_A), 32'h15A);

        bus_write(2, 8'hFF, 2);
        probe(4, 1);
        chk("glitch_ignored", 32'(ROM_A), 32'h15A);
        bus_write(3, 8'h00, WR_FILT);
        probe(4, 1);
        chk("filt_exact", 32'(ROM_A), 32'h05A);

        bus_write(0, 8'h0A, 5);
        probe(10, 0);
        chk("ram_on_cs", 32'(RAM_CS), 32'h0);
        chk("ram_on_ddir", 32'(DDIR), 32'h1);
        bus_write(0, 8'h00, 5);
        probe(10, 0);
        chk("ram_off_cs", 32'(RAM_CS), 32'h1);

        bus_write(1, 8'hEA, 4);
        bus_write(4, 8'h10, 4);
        probe(10, 0);
        chk("menu_hides_ram", 32'(RAM_CS), 32'h1);
        bus_write(11, 8'h02, 4);
        bus_write(10, 8'h01, 4);
        probe(4, 0);
        chk("lock_rom_top", 32'(ROM_A[8:7]), 32'h2);
        chk("lock_ram_top", 32'(RAM_A[3:2]), 32'h2);
        bus_write(4, 8'h10, 4);
        bus_write(11, 8'h01, 4);
        bus_write(10, 8'h00, 4);
        probe(11, 0);
        chk("sel_sticky", 32'(ROM_A[8:7]), 32'h2);
        chk("menu_forced_off", 32'(RAM_CS), 32'h0);

        @(negedge CLK);
        GB_A  = 4'h2;
        GB_D  = 8'h77;
        GB_WR = 1'b0;
        repeat (5) @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        GB_WR = 1'b1;
        RST_N = 1'b1;
        model_reset();
        repeat (6) @(negedge CLK);
        probe(4, 0);
        chk("reset_aborts", 32'(ROM_A), 32'h001);

        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 59) do_reset();
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 5))
                    0: a = 0;
                    1: a = 2;
                    2: a = 3;
                    3: a = 4;
                    4: a = 10;
                    default: a = 11;
                endcase
            end else begin
                a = $urandom_range(0, 15);
            end
            d   = $urandom_range(0, 255);
            low = $urandom_range(1, 6);
            bus_write(a, d, low);
            probe($urandom_range(0, 15), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
